// File: rtl/mem_arb_pkg.sv
// Shared defaults, requester ids and the read-tag record for the memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 6;
  localparam int RD_LAT = 1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered pointer
// to the most recently granted requester.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic RESET,
  input  logic valid0_i,
  input  logic valid1_i,
  output logic grant0_o,
  output logic grant1_o,
  output logic last_o
);

  logic last_q, last_d;
  logic grant0_d, grant1_d;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    if (!RESET) begin
      if (valid0_i && valid1_i) begin
        grant0_d = (last_q == REQ1);
        grant1_d = (last_q == REQ0);
      end else begin
        grant0_d = valid0_i;
        grant1_d = valid1_i;
      end
    end
    last_d = last_q;
    if (grant0_d) begin
      last_d = REQ0;
    end else if (grant1_d) begin
      last_d = REQ1;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      last_q <= REQ1;
    end else begin
      last_q <= last_d;
    end
  end

  assign grant0_o = grant0_d;
  assign grant1_o = grant1_d;
  assign last_o   = last_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory sequencer: round-robin grant, registered memory command,
// and a read-tag pipe that steers returning data to the requester that asked.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W,
  parameter int RD_LAT = mem_arb_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic gnt0, gnt1, arb_last;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .RESET    (RESET),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .grant0_o (gnt0),
    .grant1_o (gnt1),
    .last_o   (arb_last)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;
  tag_t              tag_d;
  tag_t              tag_q [RD_LAT+1];
  tag_t              tail;

  always_comb begin
    mem_address_d = '0;
    mem_data_d    = '0;
    mem_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    tag_d         = '0;
    if (gnt0 || gnt1) begin
      mem_address_d = gnt1 ? req1_addr : req0_addr;
      if (gnt1 ? req1_write : req0_write) begin
        mem_write_d = 1'b1;
        mem_data_d  = gnt1 ? req1_data : req0_data;
      end else begin
        mem_read_d  = 1'b1;
        tag_d.valid = 1'b1;
        tag_d.id    = gnt1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
    end else begin
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
    end
  end

  // Stage RD_LAT lines up with the cycle in which mem_rdata is valid.
  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tail = tag_q[RD_LAT];

  logic              rsp0_valid_q, rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_data_q, rsp1_data_q;

  always_ff @(posedge clk) begin
    if (RESET) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      rsp0_valid_q <= tail.valid && (tail.id == REQ0);
      rsp1_valid_q <= tail.valid && (tail.id == REQ1);
      if (tail.valid && (tail.id == REQ0)) rsp0_data_q <= mem_rdata;
      if (tail.valid && (tail.id == REQ1)) rsp1_data_q <= mem_rdata;
    end
  end

  // The newest tag was pushed on the same edge that moved the pointer.
  always_ff @(posedge clk) begin
    if (!RESET && tag_q[0].valid) begin
      assert (tag_q[0].id == arb_last);
    end
  end

  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_data   = rsp0_data_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_data   = rsp1_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked against
// a transaction-level model (grant rule, shadow memory, queue of due responses).
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       RESET;
  logic       req0_valid, req0_write, req1_valid, req1_write;
  logic [2:0] req0_addr, req1_addr;
  logic [5:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [5:0] rsp0_data, rsp1_data;
  logic [2:0] mem_address;
  logic [5:0] mem_data;
  logic       mem_write, mem_read;
  logic [5:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(3), .DATA_W(6), .RD_LAT(1)) dut (
    .clk(clk), .RESET(RESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  // Behavioural 8x6 memory with one cycle of read latency.
  logic [5:0] tbmem [8];
  logic       preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      tbmem[2] <= 6'd3;
      tbmem[5] <= 6'd6;
    end
    if (mem_write) tbmem[mem_address] <= mem_data;
    if (mem_read)  mem_rdata <= tbmem[mem_address];
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  typedef struct {
    int         due;
    logic       id;
    logic [5:0] data;
  } pend_t;

  pend_t      pend[$];
  logic [5:0] shadow [8];
  logic       last_m = 1'b1;
  logic       exp_mw = 0, exp_mr = 0;
  logic [2:0] exp_ma = 0;
  logic [5:0] exp_md = 0;
  logic       exp_rv0 = 0, exp_rv1 = 0;
  logic [5:0] exp_rd0 = 0, exp_rd1 = 0;
  int         wait0 = 0, wait1 = 0;
  int         rsp0_cnt = 0, rsp1_cnt = 0;

  logic       c_v [2];
  logic       c_w [2];
  logic [2:0] c_a [2];
  logic [5:0] c_d [2];
  logic       gm  [2];

  task automatic apply();
    req0_valid = c_v[0]; req0_write = c_w[0]; req0_addr = c_a[0]; req0_data = c_d[0];
    req1_valid = c_v[1]; req1_write = c_w[1]; req1_addr = c_a[1]; req1_data = c_d[1];
  endtask

  task automatic retire();
    for (int i = 0; i < 2; i++) if (gm[i]) c_v[i] = 1'b0;
  endtask

  task automatic set_cmd(input int i, input logic v, input logic w, input logic [2:0] a, input logic [5:0] d);
    c_v[i] = v; c_w[i] = w; c_a[i] = a; c_d[i] = d;
  endtask

  // One clock cycle: entered at posedge+1 with inputs applied, returns at next posedge+1.
  task automatic step();
    logic g0, g1, wsel;
    logic [2:0] a;
    logic [5:0] d;
    pend_t p;
    #1;
    if (RESET) begin
      g0 = 1'b0; g1 = 1'b0;
    end else if (req0_valid && req1_valid) begin
      g0 = last_m;
      g1 = !last_m;
    end else begin
      g0 = req0_valid;
      g1 = req1_valid;
    end
    check("ready0", req0_ready, g0);
    check("ready1", req1_ready, g1);
    check("mem_write", mem_write, exp_mw);
    check("mem_read", mem_read, exp_mr);
    check("mem_address", mem_address, exp_ma);
    check("mem_data", mem_data, exp_md);
    check("strobe_excl", mem_write & mem_read, 0);
    check("rsp0_valid", rsp0_valid, exp_rv0);
    check("rsp0_data", rsp0_data, exp_rd0);
    check("rsp1_valid", rsp1_valid, exp_rv1);
    check("rsp1_data", rsp1_data, exp_rd1);
    if (rsp0_valid === 1'b1) rsp0_cnt++;
    if (rsp1_valid === 1'b1) rsp1_cnt++;
    if (req0_valid && !RESET && req0_ready !== 1'b1) wait0++; else wait0 = 0;
    if (req1_valid && !RESET && req1_ready !== 1'b1) wait1++; else wait1 = 0;
    check("starve0", (wait0 > 2), 0);
    check("starve1", (wait1 > 2), 0);

    exp_mw = 0; exp_mr = 0; exp_ma = 0; exp_md = 0;
    if (g0 || g1) begin
      wsel = g1 ? req1_write : req0_write;
      a    = g1 ? req1_addr  : req0_addr;
      d    = g1 ? req1_data  : req0_data;
      if (wsel) begin
        shadow[a] = d;
        exp_mw = 1; exp_ma = a; exp_md = d;
      end else begin
        exp_mr = 1; exp_ma = a;
        pend.push_back('{cyc + 3, g1, shadow[a]});
      end
      last_m = g1;
      $display("txn cyc=%0d req%0d %s addr=%0d data=%0h", cyc, g1, wsel ? "WR" : "RD", a,
               wsel ? d : shadow[a]);
    end
    exp_rv0 = 0; exp_rv1 = 0;
    if (pend.size() > 0 && pend[0].due == cyc + 1) begin
      p = pend.pop_front();
      if (p.id) begin exp_rv1 = 1; exp_rd1 = p.data; end
      else      begin exp_rv0 = 1; exp_rd0 = p.data; end
    end
    if (RESET) begin
      last_m = 1; pend.delete();
      exp_mw = 0; exp_mr = 0; exp_ma = 0; exp_md = 0;
      exp_rv0 = 0; exp_rv1 = 0; exp_rd0 = 0; exp_rd1 = 0;
    end
    gm[0] = g0; gm[1] = g1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    set_cmd(0, 0, 0, 0, 0);
    set_cmd(1, 0, 0, 0, 0);
    apply();
    step();
    RESET = 1'b0;
  endtask

  task automatic idle(input int n);
    c_v[0] = 0; c_v[1] = 0;
    apply();
    repeat (n) step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) shadow[i] = 6'd0;
    RESET = 1'b1;
    set_cmd(0, 0, 0, 0, 0);
    set_cmd(1, 0, 0, 0, 0);
    gm[0] = 0; gm[1] = 0;
    apply();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single writer fills 0..7 with 1..8, then reads them back.
    rsp0_cnt = 0; rsp1_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      set_cmd(0, 1, 1, 3'(i), 6'(i + 1)); apply(); step(); retire();
    end
    for (int i = 0; i < 8; i++) begin
      set_cmd(0, 1, 0, 3'(i), 0); apply(); step(); retire();
    end
    idle(4);
    check("wr_rsp0_count", 8'(rsp0_cnt), 8);
    check("wr_rsp1_count", 8'(rsp1_cnt), 0);

    // Contention from the first cycle after reset, memory preloaded 2->3, 5->6.
    preload = 1'b1;
    do_reset();
    preload = 1'b0;
    shadow[2] = 6'd3; shadow[5] = 6'd6;
    rsp0_cnt = 0; rsp1_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      set_cmd(0, 1, 0, 3'd2, 0); set_cmd(1, 1, 0, 3'd5, 0);
      apply(); step(); retire();
    end
    idle(4);
    check("cont_rsp0_count", 8'(rsp0_cnt), 5);
    check("cont_rsp1_count", 8'(rsp1_cnt), 5);

    // Read-after-write on req1: data visible four cycles after the write grant.
    set_cmd(1, 1, 1, 3'd4, 6'h2A); apply(); step(); retire();
    set_cmd(1, 1, 0, 3'd4, 0);     apply(); step(); retire();
    idle(2);
    #1;
    check("raw_valid", rsp1_valid, 1);
    check("raw_data", rsp1_data, 8'h2A);
    idle(2);

    // req1 held off by a continuously valid req0; its write must land intact.
    set_cmd(0, 1, 0, 3'd1, 0);
    set_cmd(1, 1, 1, 3'd6, 6'h15);
    for (int k = 0; k < 4; k++) begin
      apply(); step();
      if (gm[1] && c_w[1]) begin
        #1;
        check("held_write", mem_write, 1);
        check("held_addr", mem_address, 6);
        check("held_data", mem_data, 8'h15);
      end
      retire();
      if (!c_v[0]) set_cmd(0, 1, 0, 3'(k + 2), 0);
    end
    c_v[0] = 0;
    set_cmd(1, 1, 0, 3'd6, 0); apply(); step(); retire();
    idle(4);

    // Reset one cycle after a read grant: the read never answers.
    set_cmd(0, 1, 0, 3'd3, 0); set_cmd(1, 0, 0, 0, 0); apply(); step(); retire();
    do_reset();
    rsp0_cnt = 0; rsp1_cnt = 0;
    idle(4);
    check("rst_no_rsp", 8'(rsp0_cnt + rsp1_cnt), 0);
    set_cmd(0, 1, 0, 3'd2, 0); set_cmd(1, 1, 0, 3'd5, 0); apply();
    #1;
    check("rst_first_gnt0", req0_ready, 1);
    check("rst_first_gnt1", req1_ready, 0);
    step(); retire();
    idle(4);

    // Random mix; unaccepted commands are held until granted.
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!c_v[i]) begin
          set_cmd(i, ($urandom_range(0, 99) < 70), 1'($urandom), 3'($urandom), 6'($urandom));
        end
      end
      apply(); step(); retire();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the 8-entry × 6-bit memory. Each requester issues single-word read or write commands over a valid/ready handshake. The arbiter grants one command per cycle with round-robin fairness and drives the memory's `address`/`data`/`write`/`read` pins from registers. It routes each read's returned data back to the requester that issued it, tagged by a pipeline that matches the memory's read latency.

## Interface
Parameters:
- `ADDR_W`, 3, memory address width (8 entries)
- `DATA_W`, 6, memory word width
- `RD_LAT`, 1, cycles from the edge that samples `mem_read` to `mem_rdata` being valid

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `RESET`  in  1  synchronous reset, active-high
- `req0_valid`, `req1_valid`  in  1  command present
- `req0_write`, `req1_write`  in  1  1 = write, 0 = read
- `req0_addr`, `req1_addr`  in  ADDR_W  target address
- `req0_data`, `req1_data`  in  DATA_W  write data (ignored for reads)
- `req0_ready`, `req1_ready`  out  1  grant; a command transfers when valid && ready
- `rsp0_valid`, `rsp1_valid`  out  1  one-cycle pulse, read data available
- `rsp0_data`, `rsp1_data`  out  DATA_W  read data
- `mem_address`  out  ADDR_W  memory address
- `mem_data`  out  DATA_W  memory write data
- `mem_write`  out  1  memory write strobe
- `mem_read`  out  1  memory read strobe
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- `reqN_ready` is combinational from the `valid` inputs and the round-robin pointer `last` (id of the most recent grant).
  - At most one ready is high per cycle.
  - Ready is high only when the same requester's valid is high.
- Arbitration:
  - Only one valid → that requester is granted.
  - Both valid → the requester ≠ `last` is granted.
  - `last` updates only on a grant.
- On a grant, the command registers into `mem_*` for exactly one cycle:
  - write → `mem_write`=1, `mem_address`/`mem_data` from the request.
  - read → `mem_read`=1, `mem_address` from the request, `mem_data`=0.
- No grant → `mem_write`=`mem_read`=0 and `mem_address`=`mem_data`=0.
- `mem_write` and `mem_read` are never high in the same cycle.
- Each read pushes {valid, id} into a tag shift register of depth RD_LAT+1.
  - At the tail, `mem_rdata` is registered into `rspX_data` of the tagged requester, and that requester's `rspX_valid` pulses.
  - The other requester's rsp outputs keep `rsp_valid`=0 and hold their data.
- Writes produce no response.
- Commands reach memory in grant order. A read granted the cycle after a write to the same address returns the new data.
- Throughput is one command per cycle with no bubbles. A single active requester may be granted every cycle.
- Starvation bound: a requester holding valid is granted within 2 cycles.

## Timing
- Reset values: all ready, rsp_valid, rsp_data, `mem_*` outputs = 0; tag pipe cleared; `last`=1, so req0 wins the first contention.
- Reset mid-operation:
  - Any in-flight read is dropped, with no rsp pulse after RESET.
  - The `mem_*` strobes are 0 in the cycle after RESET is sampled.
- Latency with grant in cycle N:
  - `mem_*` is valid in cycle N+1.
  - The memory samples at the end of N+1.
  - `mem_rdata` is valid in N+1+RD_LAT.
  - `rspX_valid` and `rspX_data` are valid in N+2+RD_LAT, i.e. N+3 for the default.
- A requester may drop or change its command only after the edge on which valid && ready was seen. An unaccepted command must be held.
- Back-to-back reads produce back-to-back rsp pulses in the same order.

## Structure
- Package `mem_arb_pkg`: `ADDR_W`, `DATA_W`, `RD_LAT` defaults, requester id localparams `REQ0`=0 and `REQ1`=1, and the tag struct {valid, id}.
- Sub-module `rr_arbiter2`: 2-way round-robin.
  - Inputs: clk, RESET, two valid bits.
  - Outputs: two one-hot grants and the `last` pointer.
- The top level holds the command mux, `mem_*` output registers, tag pipe, and response demux.

## Test plan
- Single writer, then reads: req0 writes 1..8 to addresses 0..7 on consecutive cycles, then reads 0..7.
  - Required: ready high every cycle, `mem_write` pulses for 8 cycles, `rsp0_data` = 1..8 in order starting 3 cycles after the first read grant, `rsp1_valid` never high.
- Contention: both valid from the first cycle after reset, req0 reads addr 2, req1 reads addr 5, with memory preloaded as 2→3 and 5→6.
  - Required: grants alternate req0, req1, req0, …; `rsp0_data`=3 and `rsp1_data`=6 alternate.
- Read-after-write: req1 writes 0x2A to addr 4 in cycle N, then reads addr 4 in N+1.
  - Required: `rsp1_data`=0x2A in N+4.
- Mutual exclusion: random valid/write mix for 500 cycles.
  - Required: `mem_write` && `mem_read` never both 1, and a waiting requester is never ungranted for more than 2 cycles.
- Reset mid-operation: assert RESET one cycle after a read grant.
  - Required: no rsp pulse after reset, all outputs 0, and the first contention after reset grants req0.
- Held request: req1 is held off by req0 while req0 holds valid.
  - Required: req1's command is issued unchanged on its grant cycle, and its data and address are not corrupted.
